ofdm_bin_slicer: RTL and testbench

- Parametrised demodulation back end of the OFDM receive chain; sits after the FFT engine inside ofdmdec.
- Accepts one frame of NPT frequency bins in natural order and measures the pilot-bin magnitude.
- Slices each data bin against pilot-scaled thresholds into an L=2^BPS level code, packs the codes into one output word and pushes it once per frame.
- Generalises the current fixed 128-point / 24-bin / 2-bit / pilot-55 decoder in bin count, bin placement, bits per bin and sample width.

---
 rtl/ofdm_bin_slicer_if.sv | 24 ++
 rtl/ofdm_bin_slicer.sv | 155 +++++++++++++++
 tb/tb_ofdm_bin_slicer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ofdm_bin_slicer_if.sv
// Bin-stream bus between the FFT engine and the bin slicer.
// The master drives the bins; the slave returns the packed codes and status pulses.
interface ofdm_bin_slicer_if #(
  parameter int DW = 17,
  parameter int OW = 48
);
  logic                 Pushin;
  logic                 FirstData;
  logic signed [DW-1:0] DinR;
  logic signed [DW-1:0] DinI;
  logic                 PushOut;
  logic [OW-1:0]        DataOut;
  logic                 FrameErr;

  modport master (
    output Pushin, FirstData, DinR, DinI,
    input  PushOut, DataOut, FrameErr
  );

  modport slave (
    input  Pushin, FirstData, DinR, DinI,
    output PushOut, DataOut, FrameErr
  );
endinterface

// File: rtl/ofdm_bin_slicer.sv
// OFDM demodulation back end: collects one frame of FFT bins, measures the pilot,
// slices each data bin against pilot-scaled thresholds and emits one packed word.
module ofdm_bin_slicer #(
  parameter int NPT       = 128,
  parameter int DW        = 17,
  parameter int FIRST_BIN = 4,
  parameter int BIN_STEP  = 2,
  parameter int NUM_SYM   = 24,
  parameter int BPS       = 2,
  parameter int PILOT_BIN = 55
) (
  input logic Clk,
  input logic Reset,
  ofdm_bin_slicer_if.slave bus
);
  localparam int L  = 1 << BPS;
  localparam int CW = $clog2(NPT);
  localparam int SW = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;
  localparam int MW = DW + 1;
  localparam int PW = DW + BPS + 3;
  localparam int OW = NUM_SYM * BPS;

  typedef enum logic [1:0] {IDLE, COLLECT, SLICE, OUT} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] sym_q;
  logic [MW-1:0] pilot_q;
  logic [OW-1:0] codes_q;
  logic [OW-1:0] dataOut_q;
  logic          pushOut_q;
  logic          frameErr_q;
  logic [MW-1:0] buf_q [NUM_SYM];

  logic signed [DW:0] extR, extI;
  logic [MW-1:0]      absR, absI, mag;
  logic [CW-1:0]      binIdx;
  logic               start, accept, lastBin;
  logic [MW-1:0]      pilot_d;
  logic [PW-1:0]      lhs, rhs;
  logic [BPS-1:0]     code;

  assign bus.PushOut  = pushOut_q;
  assign bus.DataOut  = dataOut_q;
  assign bus.FrameErr = frameErr_q;

  // The most negative input widens by one bit so its absolute value is exact.
  always_comb begin
    extR    = {bus.DinR[DW-1], bus.DinR};
    extI    = {bus.DinI[DW-1], bus.DinI};
    absR    = extR[DW] ? $unsigned(-extR) : $unsigned(extR);
    absI    = extI[DW] ? $unsigned(-extI) : $unsigned(extI);
    mag     = absR + absI;
    start   = bus.Pushin && bus.FirstData;
    accept  = bus.Pushin && ((state_q == IDLE && bus.FirstData) || state_q == COLLECT);
    binIdx  = (state_q == IDLE || bus.FirstData) ? '0 : cnt_q;
    lastBin = (int'(binIdx) == NPT - 1);
    if (int'(binIdx) == PILOT_BIN) begin
      pilot_d = mag;
    end else if (start) begin
      pilot_d = '0;
    end else begin
      pilot_d = pilot_q;
    end
  end

  // Code = count of thresholds (2k-1)/(2(L-1)) * pilot reached; ties round up.
  always_comb begin
    code = '0;
    rhs  = '0;
    lhs  = PW'(2 * (L - 1)) * PW'(buf_q[sym_q]);
    for (int k = 1; k < L; k++) begin
      rhs = PW'(2 * k - 1) * PW'(pilot_q);
      if (lhs >= rhs) begin
        code = code + BPS'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (accept) begin
      for (int s = 0; s < NUM_SYM; s++) begin
        if (int'(binIdx) == FIRST_BIN + s * BIN_STEP) begin
          buf_q[s] <= mag;
        end
      end
    end
  end

  // Frame sequencer; a FirstData outside IDLE always flags a lost frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sym_q      <= '0;
      pilot_q    <= '0;
      codes_q    <= '0;
      dataOut_q  <= '0;
      pushOut_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      pushOut_q  <= 1'b0;
      frameErr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q   <= CW'(1);
            pilot_q <= pilot_d;
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          if (bus.Pushin) begin
            pilot_q <= pilot_d;
            if (bus.FirstData) begin
              frameErr_q <= 1'b1;
              cnt_q      <= CW'(1);
            end else if (lastBin) begin
              cnt_q <= '0;
              sym_q <= '0;
              if (pilot_d == '0) begin
                frameErr_q <= 1'b1;
                state_q    <= IDLE;
              end else begin
                state_q <= SLICE;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        SLICE: begin
          if (start) begin
            frameErr_q <= 1'b1;
          end
          codes_q[int'(sym_q) * BPS +: BPS] <= code;
          if (sym_q == SW'(NUM_SYM - 1)) begin
            state_q <= OUT;
          end else begin
            sym_q <= sym_q + SW'(1);
          end
        end
        OUT: begin
          if (start) begin
            frameErr_q <= 1'b1;
          end
          dataOut_q <= codes_q;
          pushOut_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ofdm_bin_slicer.sv
// Scoreboard bench for ofdm_bin_slicer: a default build and a small 64-point,
// 3-bit build share the clock; monitors pop expected words on each PushOut.
module tb_ofdm_bin_slicer;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   lastCycA = 0, lastCycB = 0;
  int   errCntA = 0, errCntB = 0;
  int   pushCntA = 0, pushCntB = 0;

  logic [47:0] expA[$];
  logic [23:0] expB[$];
  logic signed [16:0] fR [128];
  logic signed [16:0] fI [128];

  ofdm_bin_slicer_if #(.DW(17), .OW(48)) ifA ();
  ofdm_bin_slicer_if #(.DW(17), .OW(24)) ifB ();

  ofdm_bin_slicer dutA (.Clk(clk), .Reset(reset), .bus(ifA));

  ofdm_bin_slicer #(
    .NPT(64), .DW(17), .FIRST_BIN(2), .BIN_STEP(1),
    .NUM_SYM(8), .BPS(3), .PILOT_BIN(20)
  ) dutB (.Clk(clk), .Reset(reset), .bus(ifB));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitors: every PushOut must match the oldest queued word and the fixed latency.
  always @(negedge clk) begin
    if (ifA.FrameErr) errCntA++;
    if (ifA.PushOut) begin
      pushCntA++;
      checks++;
      if (expA.size() == 0) begin
        failures++;
        $display("[TB] FAIL pushA_unexpected got=%h required=none", ifA.DataOut);
      end else begin
        logic [47:0] e;
        e = expA.pop_front();
        if (ifA.DataOut !== e) begin
          failures++;
          $display("[TB] FAIL pushA_data got=%h required=%h", ifA.DataOut, e);
        end
      end
      checks++;
      if (cyc - lastCycA != 25) begin
        failures++;
        $display("[TB] FAIL pushA_latency got=%0d required=25", cyc - lastCycA);
      end
    end
  end

  always @(negedge clk) begin
    if (ifB.FrameErr) errCntB++;
    if (ifB.PushOut) begin
      pushCntB++;
      checks++;
      if (expB.size() == 0) begin
        failures++;
        $display("[TB] FAIL pushB_unexpected got=%h required=none", ifB.DataOut);
      end else begin
        logic [23:0] e;
        e = expB.pop_front();
        if (ifB.DataOut !== e) begin
          failures++;
          $display("[TB] FAIL pushB_data got=%h required=%h", ifB.DataOut, e);
        end
      end
      checks++;
      if (cyc - lastCycB != 9) begin
        failures++;
        $display("[TB] FAIL pushB_latency got=%0d required=9", cyc - lastCycB);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s got=%h required=%h", name, act, req);
    end
  endtask

  task automatic clearFrame();
    for (int i = 0; i < 128; i++) begin
      fR[i] = '0;
      fI[i] = '0;
    end
  endtask

  // Symbols cycle through 0, 1/3, 2/3, 1 of a 16384 pilot.
  task automatic fillNominal();
    clearFrame();
    fR[55] = 17'sd16384;
    for (int s = 0; s < 24; s++) begin
      case (s % 4)
        0: fR[4 + 2 * s] = 17'sd0;
        1: fR[4 + 2 * s] = 17'sd5461;
        2: fR[4 + 2 * s] = 17'sd10923;
        default: fR[4 + 2 * s] = 17'sd16384;
      endcase
    end
  endtask

  task automatic driveA(input bit p, input bit f, input logic signed [16:0] r, input logic signed [16:0] im);
    ifA.Pushin = p; ifA.FirstData = f; ifA.DinR = r; ifA.DinI = im;
    @(posedge clk); #1;
    ifA.Pushin = 1'b0; ifA.FirstData = 1'b0;
  endtask

  task automatic applyStimulus(input int nBins, input bit withStalls);
    for (int b = 0; b < nBins; b++) begin
      if (withStalls && (b % 17 == 5)) driveA(1'b0, 1'b1, 17'sd0, 17'sd0);
      driveA(1'b1, b == 0, fR[b], fI[b]);
    end
    if (nBins == 128) lastCycA = cyc;
  endtask

  task automatic applyStimulusB();
    for (int b = 0; b < 64; b++) begin
      ifB.Pushin = 1'b1; ifB.FirstData = (b == 0); ifB.DinR = fR[b]; ifB.DinI = fI[b];
      @(posedge clk); #1;
    end
    ifB.Pushin = 1'b0; ifB.FirstData = 1'b0;
    lastCycB = cyc;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((expA.size() != 0 || expB.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("drain_timeout", 64'(expA.size() + expB.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    ifA.Pushin = 1'b0; ifA.FirstData = 1'b0; ifA.DinR = '0; ifA.DinI = '0;
    ifB.Pushin = 1'b0; ifB.FirstData = 1'b0; ifB.DinR = '0; ifB.DinI = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_pushA", 64'(ifA.PushOut), 64'd0);
    checkOutput("rst_errA", 64'(ifA.FrameErr), 64'd0);
    checkOutput("rst_dataA", 64'(ifA.DataOut), 64'd0);
    checkOutput("rst_dataB", 64'(ifB.DataOut), 64'd0);
    reset = 1'b0;

    // Bins without FirstData while idle are dropped.
    repeat (3) driveA(1'b1, 1'b0, 17'sd100, 17'sd100);

    fillNominal();
    expA.push_back(48'hE4E4E4E4E4E4);
    applyStimulus(128, 1'b1);
    waitDrain();

    clearFrame();
    fR[55] = 17'sd6000;
    fR[4] = 17'sd1000; fR[6] = 17'sd999; fR[8] = 17'sd3000; fR[10] = 17'sd5000;
    expA.push_back(48'h0000000000E1);
    applyStimulus(128, 1'b0);
    waitDrain();

    // Negative parts and the most negative input; FirstData while slicing is rejected.
    clearFrame();
    fR[55] = 17'sd16384;
    fR[4] = -17'sd8000; fI[4] = -17'sd8384;
    fR[6] = -17'sd65536;
    expA.push_back(48'h00000000000F);
    applyStimulus(128, 1'b0);
    driveA(1'b1, 1'b1, 17'sd5, 17'sd5);
    waitDrain();
    checkOutput("busy_err", 64'(errCntA), 64'd1);

    fillNominal();
    applyStimulus(70, 1'b0);
    clearFrame();
    fR[55] = 17'sd16384;
    for (int s = 0; s < 24; s++) fR[4 + 2 * s] = 17'sd16384;
    expA.push_back(48'hFFFFFFFFFFFF);
    applyStimulus(128, 1'b0);
    waitDrain();
    checkOutput("resync_err", 64'(errCntA), 64'd2);

    clearFrame();
    fR[4] = 17'sd1000;
    applyStimulus(128, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    checkOutput("pilot0_err", 64'(errCntA), 64'd3);
    checkOutput("pilot0_hold", 64'(ifA.DataOut), 64'hFFFFFFFFFFFF);

    fillNominal();
    applyStimulus(128, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("midrst_data", 64'(ifA.DataOut), 64'd0);
    checkOutput("midrst_push", 64'(ifA.PushOut), 64'd0);
    repeat (30) @(posedge clk);
    #1;
    checkOutput("midrst_nopush", 64'(pushCntA), 64'd4);

    fillNominal();
    expA.push_back(48'hE4E4E4E4E4E4);
    applyStimulus(128, 1'b1);
    waitDrain();

    // Small build: level k of 7 at k*pilot/7 decodes to code k.
    clearFrame();
    fR[20] = 17'sd7000;
    for (int k = 0; k < 8; k++) fR[2 + k] = 17'(1000 * k);
    expB.push_back(24'hFAC688);
    applyStimulusB();
    waitDrain();

    checkOutput("pushA_total", 64'(pushCntA), 64'd5);
    checkOutput("pushB_total", 64'(pushCntB), 64'd1);
    checkOutput("errA_total", 64'(errCntA), 64'd3);
    checkOutput("errB_total", 64'(errCntB), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
